nn_param_streamer: RTL and testbench
====================================

Name: nn_param_streamer

Overview:
- Upstream feeder for the neuron-array master engine.
- Holds the weight and bias words for the whole network in two on-chip banks, loaded by the host before a run.
- During a run, presents the next word on wt_in / bias_in every cycle the engine pulses weight_en / bias_en. The engine shifts one word into its bank per enable cycle.
- Checks every enable burst against the configured neuron count of the current layer and flags overrun and length errors.

Parameters:
- DATA_W, 16, fixed-point word width of weights and biases.
- W_DEPTH, 4096, weight bank depth in words; must cover the sum over layers of fan_in*neurons.
- B_DEPTH, 320, bias bank depth in words; must cover 5 layers * 64 neurons.
- NL_W, 6, width of layer index and neuron counts.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse: rewind pointers, clear errors, prime outputs.
- cfg_wr_en  in  1  host write strobe.
- cfg_wr_sel  in  1  host write target: 0 = weight bank, 1 = bias bank.
- cfg_wr_data  in  DATA_W  host write word; written at the bank's write pointer.
- cfg_clr  in  1  pulse: zero both write pointers and lengths (new network image).
- nl1..nl5  in  NL_W each  neuron count per layer.
- n  in  NL_W  current layer index from the engine.
- weight_en  in  1  engine consumes wt_in this cycle.
- bias_en  in  1  engine consumes bias_in this cycle.
- wt_in  out  DATA_W  current weight word.
- bias_in  out  DATA_W  current bias word.
- ready  out  1  outputs primed; the engine may be started.
- w_len  out  log2(W_DEPTH)+1  weight words loaded.
- b_len  out  log2(B_DEPTH)+1  bias words loaded.
- err_overrun  out  1  sticky: an enable arrived after that bank was exhausted.
- err_burst  out  1  sticky: an enable burst length differed from nl[n].
- err_wr_busy  out  1  sticky: a host write was attempted during PRIME or RUN.

Behaviour:
- Reset:
  - state = IDLE.
  - All pointers, lengths and counters are 0.
  - wt_in = bias_in = 0; ready = 0; all err_* = 0.
  - Bank contents are not reset.
- States: IDLE, PRIME, RUN.
- IDLE:
  - cfg_wr_en writes cfg_wr_data to the selected bank at its write pointer, then increments that pointer and length.
  - A write to a full bank (length == depth) is dropped; the length saturates.
  - cfg_clr zeroes both write pointers and lengths. If cfg_clr and cfg_wr_en coincide, cfg_clr wins and the write is dropped.
- start (any state):
  - rd pointers := 0; issue bank reads at address 0; clear all err_*.
  - Go to PRIME; ready = 0.
  - start during RUN is a restart.
  - start with w_len == 0 still primes; the first enable then raises err_overrun.
- PRIME: one cycle, registered read returns; go to RUN with ready = 1. ready rises 2 clk after the start pulse.
- RUN, weight path (bias path identical, with its own pointer):
  - Invariant: wt_in = wbank[w_rd].
  - Read address = w_rd + weight_en. The bank output is registered, so on the edge where weight_en is sampled, w_rd advances and wt_in updates to the next word. Zero bubbles; back-to-back enables are allowed.
  - If weight_en is high and w_rd == w_len: set err_overrun; wt_in := 0; w_rd holds.
- Storage order is consumption order. Per layer, per input i, weights for neurons nl[n]-1 down to 0, because the engine's first-shifted word ends in the highest bank slot. The block does no address reordering.
- Burst check, separate counters for weight and bias:
  - The counter increments on each enable cycle.
  - On the first cycle with the enable low after a burst, compare the count to nl[n] (n sampled at burst end). Mismatch sets err_burst. The counter then clears.
  - nl index: n = 0..4 maps to nl1..nl5; n > 4 compares against 0, so any burst is an error.
- cfg_wr_en in PRIME/RUN is ignored and sets err_wr_busy.
- An asynchronous reset mid-run returns to IDLE immediately. Loaded lengths are lost; the host must reload.
- Top-level sequencing: the engine's start must follow ready.

Decomposition:
- Package nn_stream_pkg holds:
  - DATA_W and NL_W defaults.
  - State encoding IDLE/PRIME/RUN.
  - WSEL_WEIGHT = 0, WSEL_BIAS = 1.
  - MAX_LAYERS = 5.
- Sub-module nn_param_bank: simple dual-port RAM with a sync write port and a registered sync read port, parameterised by depth and width. It is instanced twice, for weights and biases.

Test Plan:
- Zero-bubble streaming: load weights 0x0001..0x0006 and 2 biases; start; wait for ready; pulse weight_en for 6 consecutive cycles with nl1 = 3, n = 0, broken into two bursts of 3 -> wt_in sampled = 1,2,3,4,5,6; err_burst = 0.
- Burst mismatch: nl1 = 4, weight_en burst of 3 -> err_burst = 1 on the cycle after the burst ends; a following start clears it to 0.
- Overrun: w_len = 2; 3 weight_en cycles -> samples 1, 2, then 0; err_overrun = 1; w_rd stays 2.
- Priming: start pulse at cycle t -> ready = 0 at t+1, ready = 1 at t+2, wt_in = wbank[0] at t+2.
- Host protection: cfg_wr_en during RUN -> err_wr_busy = 1 and w_len unchanged. cfg_clr coinciding with cfg_wr_en in IDLE -> w_len = 0.
- Async reset: assert rst_n = 0 mid-burst -> outputs 0, ready = 0, state IDLE without waiting for a clock edge. After release, start then weight_en gives overrun immediately because w_len = 0.

Source files
------------

// File: rtl/nn_stream_pkg.sv
// nn_stream_pkg: shared widths, state encoding and host write selectors for the parameter streamer
package nn_stream_pkg;
   localparam int DATA_W_DEF = 16;
   localparam int NL_W_DEF = 6;
   localparam int MAX_LAYERS = 5;
   localparam logic WSEL_WEIGHT = 1'b0;
   localparam logic WSEL_BIAS = 1'b1;
   typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;
endpackage

// File: rtl/nn_param_bank.sv
// nn_param_bank: simple dual-port RAM, sync write, registered sync read
module nn_param_bank #(
   parameter int DEPTH = 4096,
   parameter int WIDTH = 16,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);
   logic [WIDTH-1:0] mem [DEPTH];
   // host write port; contents deliberately survive reset
   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;
   // read register is cleared so the streamed word is 0 straight out of reset
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) rdata <= '0;
      else rdata <= mem[raddr];
endmodule

// File: rtl/nn_param_streamer.sv
// nn_param_streamer: host-loaded weight/bias banks streamed to the neuron engine with burst checking
module nn_param_streamer
   import nn_stream_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int W_DEPTH = 4096,
   parameter int B_DEPTH = 320,
   parameter int NL_W = NL_W_DEF,
   localparam int WAW = $clog2(W_DEPTH),
   localparam int BAW = $clog2(B_DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              cfg_wr_en,
   input  logic              cfg_wr_sel,
   input  logic [DATA_W-1:0] cfg_wr_data,
   input  logic              cfg_clr,
   input  logic [NL_W-1:0]   nl1,
   input  logic [NL_W-1:0]   nl2,
   input  logic [NL_W-1:0]   nl3,
   input  logic [NL_W-1:0]   nl4,
   input  logic [NL_W-1:0]   nl5,
   input  logic [NL_W-1:0]   n,
   input  logic              weight_en,
   input  logic              bias_en,
   output logic [DATA_W-1:0] wt_in,
   output logic [DATA_W-1:0] bias_in,
   output logic              ready,
   output logic [WAW:0]      w_len,
   output logic [BAW:0]      b_len,
   output logic              err_overrun,
   output logic              err_burst,
   output logic              err_wr_busy
);
   localparam logic [WAW:0] W_FULL = (WAW + 1)'(W_DEPTH);
   localparam logic [BAW:0] B_FULL = (BAW + 1)'(B_DEPTH);
   state_t state, state_nxt;
   logic [WAW:0] w_rd, w_sum;
   logic [BAW:0] b_rd, b_sum;
   logic [WAW-1:0] w_raddr;
   logic [BAW-1:0] b_raddr;
   logic [DATA_W-1:0] w_q, b_q;
   logic [NL_W:0] w_cnt, b_cnt;
   logic [NL_W-1:0] nl_cur;
   logic run, idle_wr, w_we, b_we, w_avail, b_avail, w_adv, b_adv, w_bad, b_bad;

   // state register
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nxt;

   // next state, write/read control, layer size lookup and output masking
   always_comb begin
      state_nxt = start ? PRIME : (state == PRIME ? RUN : state);
      run = state == RUN;
      ready = run;
      idle_wr = state == IDLE && cfg_wr_en && !cfg_clr;
      w_we = idle_wr && cfg_wr_sel == WSEL_WEIGHT && w_len != W_FULL;
      b_we = idle_wr && cfg_wr_sel == WSEL_BIAS && b_len != B_FULL;
      w_avail = w_rd != w_len;
      b_avail = b_rd != b_len;
      w_adv = run && weight_en && w_avail;
      b_adv = run && bias_en && b_avail;
      // bank output is registered, so look one word ahead on a consuming cycle
      w_sum = w_rd + (WAW + 1)'(w_adv);
      b_sum = b_rd + (BAW + 1)'(b_adv);
      w_raddr = start ? '0 : w_sum[WAW-1:0];
      b_raddr = start ? '0 : b_sum[BAW-1:0];
      nl_cur = n == NL_W'(0) ? nl1 :
               n == NL_W'(1) ? nl2 :
               n == NL_W'(2) ? nl3 :
               n == NL_W'(3) ? nl4 :
               n == NL_W'(4) ? nl5 : '0;
      w_bad = !weight_en && w_cnt != '0 && w_cnt != {1'b0, nl_cur};
      b_bad = !bias_en && b_cnt != '0 && b_cnt != {1'b0, nl_cur};
      wt_in = (run && w_avail) ? w_q : '0;
      bias_in = (run && b_avail) ? b_q : '0;
   end

   // host load lengths double as the write pointers
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         w_len <= '0;
         b_len <= '0;
      end else if (state == IDLE && cfg_clr) begin
         w_len <= '0;
         b_len <= '0;
      end else begin
         if (w_we) w_len <= w_len + 1'b1;
         if (b_we) b_len <= b_len + 1'b1;
      end

   // read pointers rewind on start and advance once per consumed word
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         w_rd <= '0;
         b_rd <= '0;
      end else if (start) begin
         w_rd <= '0;
         b_rd <= '0;
      end else begin
         if (w_adv) w_rd <= w_rd + 1'b1;
         if (b_adv) b_rd <= b_rd + 1'b1;
      end

   // burst length counters saturate so oversize bursts still mismatch
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         w_cnt <= '0;
         b_cnt <= '0;
      end else begin
         w_cnt <= (!run || start || !weight_en) ? '0 : (&w_cnt ? w_cnt : w_cnt + 1'b1);
         b_cnt <= (!run || start || !bias_en) ? '0 : (&b_cnt ? b_cnt : b_cnt + 1'b1);
      end

   // sticky error flags, all cleared by start
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         err_overrun <= 1'b0;
         err_burst <= 1'b0;
         err_wr_busy <= 1'b0;
      end else if (start) begin
         err_overrun <= 1'b0;
         err_burst <= 1'b0;
         err_wr_busy <= 1'b0;
      end else begin
         if (run && ((weight_en && !w_avail) || (bias_en && !b_avail))) err_overrun <= 1'b1;
         if (run && (w_bad || b_bad)) err_burst <= 1'b1;
         if (cfg_wr_en && state != IDLE) err_wr_busy <= 1'b1;
      end

   nn_param_bank #(.DEPTH(W_DEPTH), .WIDTH(DATA_W)) u_wbank (
      .clk(clk), .rst_n(rst_n), .we(w_we), .waddr(w_len[WAW-1:0]),
      .wdata(cfg_wr_data), .raddr(w_raddr), .rdata(w_q)
   );

   nn_param_bank #(.DEPTH(B_DEPTH), .WIDTH(DATA_W)) u_bbank (
      .clk(clk), .rst_n(rst_n), .we(b_we), .waddr(b_len[BAW-1:0]),
      .wdata(cfg_wr_data), .raddr(b_raddr), .rdata(b_q)
   );
endmodule

// File: tb/tb_nn_param_streamer.sv
// tb_nn_param_streamer: scenario tasks with a scoreboard of expected streamed words
module tb_nn_param_streamer;
   logic clk = 0, rst_n = 0, start = 0, cfg_wr_en = 0, cfg_wr_sel = 0, cfg_clr = 0;
   logic weight_en = 0, bias_en = 0;
   logic [15:0] cfg_wr_data = 0;
   logic [5:0] nl1 = 3, nl2 = 0, nl3 = 0, nl4 = 0, nl5 = 0, n = 0;
   logic [15:0] wt_in, bias_in;
   logic ready, err_overrun, err_burst, err_wr_busy;
   logic [12:0] w_len;
   logic [9:0] b_len;
   int checks = 0, errors = 0;
   logic [15:0] exp_q[$];
   logic [15:0] exp;

   nn_param_streamer dut (
      .clk(clk), .rst_n(rst_n), .start(start), .cfg_wr_en(cfg_wr_en), .cfg_wr_sel(cfg_wr_sel),
      .cfg_wr_data(cfg_wr_data), .cfg_clr(cfg_clr), .nl1(nl1), .nl2(nl2), .nl3(nl3), .nl4(nl4),
      .nl5(nl5), .n(n), .weight_en(weight_en), .bias_en(bias_en), .wt_in(wt_in), .bias_in(bias_in),
      .ready(ready), .w_len(w_len), .b_len(b_len), .err_overrun(err_overrun), .err_burst(err_burst),
      .err_wr_busy(err_wr_busy)
   );

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task tick;
      @(posedge clk);
      #1;
   endtask

   task do_reset;
      rst_n = 0;
      #3;
      rst_n = 1;
      tick;
   endtask

   task host_write(input logic sel, input logic [15:0] d);
      cfg_wr_en = 1;
      cfg_wr_sel = sel;
      cfg_wr_data = d;
      tick;
      cfg_wr_en = 0;
   endtask

   task pulse_start;
      start = 1;
      tick;
      start = 0;
   endtask

   task wait_ready;
      int k;
      k = 0;
      while (!ready && k < 8) begin
         tick;
         k++;
      end
      checks++;
      if (ready !== 1'b1) begin
         errors++;
         $display("FAIL wait_ready timeout ready=%b exp 1", ready);
      end
   endtask

   task test_reset;
      checks++;
      if (wt_in !== 16'h0) begin errors++; $display("FAIL reset_wt_in got %h exp 0", wt_in); end
      checks++;
      if (bias_in !== 16'h0) begin errors++; $display("FAIL reset_bias_in got %h exp 0", bias_in); end
      checks++;
      if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", ready); end
      checks++;
      if (w_len !== 13'd0 || b_len !== 10'd0) begin errors++; $display("FAIL reset_len got %0d/%0d exp 0/0", w_len, b_len); end
      checks++;
      if ({err_overrun, err_burst, err_wr_busy} !== 3'b000) begin errors++; $display("FAIL reset_err got %b exp 000", {err_overrun, err_burst, err_wr_busy}); end
   endtask

   task test_host_full;
      for (int i = 0; i < 320; i++) host_write(1'b1, 16'(i));
      checks++;
      if (b_len !== 10'd320) begin errors++; $display("FAIL bias_full got %0d exp 320", b_len); end
      host_write(1'b1, 16'hFFFF);
      checks++;
      if (b_len !== 10'd320) begin errors++; $display("FAIL bias_saturate got %0d exp 320", b_len); end
      host_write(1'b0, 16'h1111);
      host_write(1'b0, 16'h2222);
      checks++;
      if (w_len !== 13'd2) begin errors++; $display("FAIL w_len_load got %0d exp 2", w_len); end
      cfg_clr = 1;
      host_write(1'b0, 16'h3333);
      cfg_clr = 0;
      checks++;
      if (w_len !== 13'd0 || b_len !== 10'd0) begin errors++; $display("FAIL clr_wins got %0d/%0d exp 0/0", w_len, b_len); end
   endtask

   task test_prime;
      for (int i = 1; i <= 6; i++) host_write(1'b0, 16'(i));
      host_write(1'b1, 16'h0A01);
      host_write(1'b1, 16'h0A02);
      checks++;
      if (w_len !== 13'd6 || b_len !== 10'd2) begin errors++; $display("FAIL load_len got %0d/%0d exp 6/2", w_len, b_len); end
      pulse_start;
      checks++;
      if (ready !== 1'b0) begin errors++; $display("FAIL prime_ready_t1 got %b exp 0", ready); end
      tick;
      checks++;
      if (ready !== 1'b1) begin errors++; $display("FAIL prime_ready_t2 got %b exp 1", ready); end
      checks++;
      if (wt_in !== 16'h0001) begin errors++; $display("FAIL prime_wt_in got %h exp 0001", wt_in); end
      checks++;
      if (bias_in !== 16'h0A01) begin errors++; $display("FAIL prime_bias_in got %h exp 0a01", bias_in); end
   endtask

   task test_stream;
      nl1 = 3;
      n = 0;
      for (int i = 1; i <= 6; i++) exp_q.push_back(16'(i));
      for (int b = 0; b < 2; b++) begin
         for (int k = 0; k < 3; k++) begin
            weight_en = 1;
            exp = exp_q.pop_front();
            checks++;
            if (wt_in !== exp) begin errors++; $display("FAIL stream_wt got %h exp %h", wt_in, exp); end
            tick;
         end
         weight_en = 0;
         tick;
      end
      checks++;
      if (err_burst !== 1'b0 || err_overrun !== 1'b0) begin errors++; $display("FAIL stream_err got %b%b exp 00", err_burst, err_overrun); end
      nl1 = 2;
      exp_q.push_back(16'h0A01);
      exp_q.push_back(16'h0A02);
      for (int k = 0; k < 2; k++) begin
         bias_en = 1;
         exp = exp_q.pop_front();
         checks++;
         if (bias_in !== exp) begin errors++; $display("FAIL stream_bias got %h exp %h", bias_in, exp); end
         tick;
      end
      bias_en = 0;
      tick;
      checks++;
      if (err_burst !== 1'b0) begin errors++; $display("FAIL bias_burst got %b exp 0", err_burst); end
   endtask

   task test_wr_busy;
      host_write(1'b0, 16'hBEEF);
      checks++;
      if (err_wr_busy !== 1'b1) begin errors++; $display("FAIL wr_busy got %b exp 1", err_wr_busy); end
      checks++;
      if (w_len !== 13'd6) begin errors++; $display("FAIL wr_busy_len got %0d exp 6", w_len); end
   endtask

   task test_burst_mismatch;
      pulse_start;
      wait_ready;
      nl1 = 4;
      weight_en = 1;
      tick;
      tick;
      tick;
      weight_en = 0;
      checks++;
      if (err_burst !== 1'b0) begin errors++; $display("FAIL burst_early got %b exp 0", err_burst); end
      tick;
      checks++;
      if (err_burst !== 1'b1) begin errors++; $display("FAIL burst_mismatch got %b exp 1", err_burst); end
      pulse_start;
      checks++;
      if (err_burst !== 1'b0 || err_wr_busy !== 1'b0) begin errors++; $display("FAIL start_clears got %b%b exp 00", err_burst, err_wr_busy); end
   endtask

   task test_layer_oob;
      wait_ready;
      n = 5;
      weight_en = 1;
      tick;
      weight_en = 0;
      tick;
      checks++;
      if (err_burst !== 1'b1) begin errors++; $display("FAIL layer_oob got %b exp 1", err_burst); end
      n = 0;
   endtask

   task test_overrun;
      do_reset;
      host_write(1'b0, 16'h0001);
      host_write(1'b0, 16'h0002);
      nl1 = 3;
      pulse_start;
      wait_ready;
      exp_q.push_back(16'h0001);
      exp_q.push_back(16'h0002);
      exp_q.push_back(16'h0000);
      exp_q.push_back(16'h0000);
      for (int k = 0; k < 4; k++) begin
         weight_en = 1;
         exp = exp_q.pop_front();
         checks++;
         if (wt_in !== exp) begin errors++; $display("FAIL overrun_wt got %h exp %h", wt_in, exp); end
         tick;
         if (k == 2) begin
            checks++;
            if (err_overrun !== 1'b1) begin errors++; $display("FAIL overrun_flag got %b exp 1", err_overrun); end
         end
      end
      weight_en = 0;
      tick;
   endtask

   task test_async_reset;
      host_write(1'b0, 16'h0055);
      pulse_start;
      wait_ready;
      weight_en = 1;
      tick;
      #2;
      rst_n = 0;
      #1;
      checks++;
      if (wt_in !== 16'h0 || bias_in !== 16'h0) begin errors++; $display("FAIL areset_out got %h/%h exp 0/0", wt_in, bias_in); end
      checks++;
      if (ready !== 1'b0 || w_len !== 13'd0) begin errors++; $display("FAIL areset_state got ready=%b w_len=%0d exp 0/0", ready, w_len); end
      weight_en = 0;
      #2;
      rst_n = 1;
      tick;
      pulse_start;
      wait_ready;
      weight_en = 1;
      checks++;
      if (wt_in !== 16'h0) begin errors++; $display("FAIL areset_wt got %h exp 0", wt_in); end
      tick;
      weight_en = 0;
      checks++;
      if (err_overrun !== 1'b1) begin errors++; $display("FAIL areset_overrun got %b exp 1", err_overrun); end
   endtask

   initial begin
      #12;
      rst_n = 1;
      tick;
      test_reset;
      test_host_full;
      test_prime;
      test_stream;
      test_wr_busy;
      test_burst_mismatch;
      test_layer_oob;
      test_overrun;
      test_async_reset;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
